add_pipe_signed: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready handshake, per-operation add/sub select, unsigned carry-out, signed overflow detection and optional saturation. The `Bits`-wide datapath is split into `Stages` equal carry-chained slices, one slice per register stage, so wide operands close timing at high clock rates. It replaces the single-cycle combinational signed adder wherever arithmetic sits on a registered streaming path.

---
 rtl/add_pipe_signed.sv | 115 +++++++++++
 tb/tb_add_pipe_signed.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_pipe_signed.sv
// add_pipe_signed: pipelined signed adder/subtractor, one carry-chained slice per stage, valid/ready, overflow, optional saturation
// Ports: clk, reset (async, active-high); in_valid/in_ready with a, b, sub (0: a+b, 1: a-b);
//        out_valid/out_ready with sum, carry (unsigned carry-out, not-borrow on subtract), overflow (signed).
module add_pipe_signed #(
  parameter int Bits     = 64,
  parameter int Stages   = 4,
  parameter bit Saturate = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [Bits-1:0] a,
  input  logic [Bits-1:0] b,
  input  logic            sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [Bits-1:0] sum,
  output logic            carry,
  output logic            overflow
);
  localparam int SB = Bits / Stages;
  localparam int UW = (Stages > 1) ? Bits - SB : 1;
  logic            w_en;
  logic [Bits-1:0] w_be;
  logic [Bits-1:0] w_raw;
  logic            w_am;
  logic            w_bm;
  // the whole pipe, bubbles included, moves only when the output slot is free or being taken
  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;
  assign w_be     = sub ? ~b : b;
  for (genvar k = 0; k < Stages; k++) begin : g
    logic            r_v;
    logic            r_c;
    logic            r_am;
    logic            r_bm;
    logic [Bits-1:0] r_raw;
    logic            w_vi;
    logic            w_ci;
    logic            w_ami;
    logic            w_bmi;
    logic [SB-1:0]   w_as;
    logic [SB-1:0]   w_bs;
    logic [Bits-1:0] w_ri;
    logic [Bits-1:0] w_ro;
    logic [SB:0]     w_s;
    if (k == 0) begin : i
      assign w_vi  = in_valid;
      assign w_ci  = sub;
      assign w_ami = a[Bits-1];
      assign w_bmi = w_be[Bits-1];
      assign w_as  = a[SB-1:0];
      assign w_bs  = w_be[SB-1:0];
      assign w_ri  = '0;
    end else begin : i
      assign w_vi  = g[k-1].r_v;
      assign w_ci  = g[k-1].r_c;
      assign w_ami = g[k-1].r_am;
      assign w_bmi = g[k-1].r_bm;
      assign w_as  = g[k-1].d.r_a[(k-1)*SB +: SB];
      assign w_bs  = g[k-1].d.r_b[(k-1)*SB +: SB];
      assign w_ri  = g[k-1].r_raw;
    end
    assign w_s = {1'b0, w_as} + {1'b0, w_bs} + {{SB{1'b0}}, w_ci};
    always_comb begin
      w_ro = w_ri;
      w_ro[k*SB +: SB] = w_s[SB-1:0];
    end
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        r_v   <= 1'b0;
        r_c   <= 1'b0;
        r_am  <= 1'b0;
        r_bm  <= 1'b0;
        r_raw <= '0;
      end else if (w_en) begin
        r_v   <= w_vi;
        r_c   <= w_s[SB];
        r_am  <= w_ami;
        r_bm  <= w_bmi;
        r_raw <= w_ro;
      end
    // upper operand slices (a[Bits-1:SB], be[Bits-1:SB]) ride along until their stage consumes them
    if (k < Stages - 1) begin : d
      logic [UW-1:0] r_a;
      logic [UW-1:0] r_b;
      logic [UW-1:0] w_ua;
      logic [UW-1:0] w_ub;
      if (k == 0) begin : s
        assign w_ua = UW'(a >> SB);
        assign w_ub = UW'(w_be >> SB);
      end else begin : s
        assign w_ua = g[k-1].d.r_a;
        assign w_ub = g[k-1].d.r_b;
      end
      always_ff @(posedge clk or posedge reset)
        if (reset) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_en) begin
          r_a <= w_ua;
          r_b <= w_ub;
        end
    end
  end
  assign out_valid = g[Stages-1].r_v;
  assign carry     = g[Stages-1].r_c;
  assign w_raw     = g[Stages-1].r_raw;
  assign w_am      = g[Stages-1].r_am;
  assign w_bm      = g[Stages-1].r_bm;
  assign overflow  = (w_am == w_bm) && (w_raw[Bits-1] != w_am);
  // clamp toward the sign of a: 0x80..0 when a is negative, 0x7F..F otherwise
  assign sum       = (Saturate && overflow) ? {w_am, {(Bits-1){!w_am}}} : w_raw;
endmodule

// File: tb/tb_add_pipe_signed.sv
// tb_add_pipe_signed: scoreboard bench for add_pipe_signed (8-bit wrap, 8-bit saturate, 64-bit wrap)
module tb_add_pipe_signed;
  typedef struct packed {
    logic [63:0] s;
    logic        c;
    logic        o;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic        v8 = 1'b0, r8 = 1'b1, s8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ir8w, ov8w, c8w, o8w, ir8s, ov8s, c8s, o8s;
  logic [7:0]  sum8w, sum8s;
  logic        v64 = 1'b0, r64 = 1'b1, s64 = 1'b0;
  logic [63:0] a64 = '0, b64 = '0;
  logic        ir64, ov64, c64, o64;
  logic [63:0] sum64;
  exp_t        q8w[$], q8s[$], q64[$];
  int          outc[$];
  bit          track = 1'b0;
  bit          rec_first = 1'b0;
  int          acc0 = 0;
  logic        p_stall = 1'b0;
  logic [63:0] p_sum = '0;
  logic        p_c = 1'b0, p_o = 1'b0;

  add_pipe_signed #(.Bits(8), .Stages(2), .Saturate(1'b0)) u8w (
    .clk(clk), .reset(rst), .in_valid(v8), .in_ready(ir8w), .a(a8), .b(b8), .sub(s8),
    .out_valid(ov8w), .out_ready(r8), .sum(sum8w), .carry(c8w), .overflow(o8w));
  add_pipe_signed #(.Bits(8), .Stages(2), .Saturate(1'b1)) u8s (
    .clk(clk), .reset(rst), .in_valid(v8), .in_ready(ir8s), .a(a8), .b(b8), .sub(s8),
    .out_valid(ov8s), .out_ready(r8), .sum(sum8s), .carry(c8s), .overflow(o8s));
  add_pipe_signed #(.Bits(64), .Stages(4), .Saturate(1'b0)) u64 (
    .clk(clk), .reset(rst), .in_valid(v64), .in_ready(ir64), .a(a64), .b(b64), .sub(s64),
    .out_valid(ov64), .out_ready(r64), .sum(sum64), .carry(c64), .overflow(o64));

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(logic [63:0] s, logic c, logic o);
    exp_t e;
    e.s = s;
    e.c = c;
    e.o = o;
    return e;
  endfunction

  // reference built on wide signed integers: overflow = result out of range, carry = unsigned compare
  function automatic exp_t model(int w, logic [63:0] x, logic [63:0] y, bit s, bit sat);
    logic signed [65:0] sx, sy, r, hi, lo;
    logic [65:0] ux, uy, m;
    exp_t e;
    ux = {2'b00, x};
    uy = {2'b00, y};
    sx = $signed(ux << (66 - w)) >>> (66 - w);
    sy = $signed(uy << (66 - w)) >>> (66 - w);
    r  = s ? sx - sy : sx + sy;
    hi = (66'sd1 <<< (w - 1)) - 66'sd1;
    lo = -hi - 66'sd1;
    m  = (66'd1 << w) - 66'd1;
    e.o = (r > hi) || (r < lo);
    e.c = s ? (ux >= uy) : (((ux + uy) >> w) != 66'd0);
    e.s = (sat && e.o) ? (sx < 0 ? 64'(lo) & m[63:0] : hi[63:0]) : 64'(r) & m[63:0];
    return e;
  endfunction

  task automatic send8(logic [7:0] x, logic [7:0] y, bit s, exp_t ew, exp_t es);
    int n = 0;
    bit acc = 1'b0;
    v8 = 1'b1; a8 = x; b8 = y; s8 = s;
    do begin
      @(negedge clk);
      acc = ir8w;
      if (acc) begin
        q8w.push_back(ew);
        q8s.push_back(es);
      end
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      n_vec++; n_bad++;
      $display("FAIL send8_timeout: in_ready stayed 0, expected 1 within 200 cycles");
    end
  endtask

  task automatic send64(logic [63:0] x, logic [63:0] y, bit s, exp_t e);
    int n = 0;
    bit acc = 1'b0;
    v64 = 1'b1; a64 = x; b64 = y; s64 = s;
    do begin
      @(negedge clk);
      acc = ir64;
      if (acc) begin
        q64.push_back(e);
        if (rec_first) begin
          acc0 = cyc + 1;
          rec_first = 1'b0;
        end
      end
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      n_vec++; n_bad++;
      $display("FAIL send64_timeout: in_ready stayed 0, expected 1 within 200 cycles");
    end
  endtask

  task automatic idle64(int n);
    v64 = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (ov8w && r8) begin
      n_vec++;
      if (q8w.size() == 0) begin
        n_bad++;
        $display("FAIL d8w_extra: out_valid=1 with no beat pending, expected 0");
      end else begin
        chk("d8w_sum", {56'd0, sum8w}, q8w[0].s);
        chk("d8w_carry", 64'(c8w), 64'(q8w[0].c));
        chk("d8w_ovf", 64'(o8w), 64'(q8w[0].o));
        void'(q8w.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (ov8s && r8) begin
      n_vec++;
      if (q8s.size() == 0) begin
        n_bad++;
        $display("FAIL d8s_extra: out_valid=1 with no beat pending, expected 0");
      end else begin
        chk("d8s_sum", {56'd0, sum8s}, q8s[0].s);
        chk("d8s_carry", 64'(c8s), 64'(q8s[0].c));
        chk("d8s_ovf", 64'(o8s), 64'(q8s[0].o));
        void'(q8s.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (p_stall) begin
      chk("stall_valid", 64'(ov64), 64'd1);
      chk("stall_sum", sum64, p_sum);
      chk("stall_carry", 64'(c64), 64'(p_c));
      chk("stall_ovf", 64'(o64), 64'(p_o));
    end
    p_stall <= ov64 && !r64;
    p_sum   <= sum64;
    p_c     <= c64;
    p_o     <= o64;
    if (ov64 && r64) begin
      if (track) outc.push_back(cyc);
      n_vec++;
      if (q64.size() == 0) begin
        n_bad++;
        $display("FAIL d64_extra: out_valid=1 with no beat pending, expected 0");
      end else begin
        chk("d64_sum", sum64, q64[0].s);
        chk("d64_carry", 64'(c64), 64'(q64[0].c));
        chk("d64_ovf", 64'(o64), 64'(q64[0].o));
        void'(q64.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at 1 ms, expected completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] x, y;
    bit s;
    int seen;
    logic [9:0] gaps;
    gaps = 10'b0100101100;
    #1;
    chk("rst_ov64", 64'(ov64), 64'd0);
    chk("rst_sum64", sum64, 64'd0);
    chk("rst_carry64", 64'(c64), 64'd0);
    chk("rst_ovf64", 64'(o64), 64'd0);
    chk("rst_ir64", 64'(ir64), 64'd1);
    chk("rst_ov8w", 64'(ov8w), 64'd0);
    chk("rst_ir8s", 64'(ir8s), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send8(8'd100, 8'd27, 1'b0, mk(64'h7F, 1'b0, 1'b0), mk(64'h7F, 1'b0, 1'b0));
    send8(8'd100, 8'd28, 1'b0, mk(64'h80, 1'b0, 1'b1), mk(64'h7F, 1'b0, 1'b1));
    send8(8'hFF, 8'h01, 1'b0, mk(64'h00, 1'b1, 1'b0), mk(64'h00, 1'b1, 1'b0));
    send8(8'h80, 8'h01, 1'b1, mk(64'h7F, 1'b1, 1'b1), mk(64'h80, 1'b1, 1'b1));
    send8(8'h05, 8'h07, 1'b1, mk(64'hFE, 1'b0, 1'b0), mk(64'hFE, 1'b0, 1'b0));
    send8(8'h80, 8'h80, 1'b0, mk(64'h00, 1'b1, 1'b1), mk(64'h80, 1'b1, 1'b1));
    send8(8'h7F, 8'h80, 1'b1, mk(64'hFF, 1'b0, 1'b1), mk(64'h7F, 1'b0, 1'b1));
    send8(8'h0F, 8'h01, 1'b0, mk(64'h10, 1'b0, 1'b0), mk(64'h10, 1'b0, 1'b0));
    send8(8'h00, 8'h00, 1'b1, mk(64'h00, 1'b1, 1'b0), mk(64'h00, 1'b1, 1'b0));
    v8 = 1'b0;
    send64(64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, mk(64'h0001_0000_0000_0000, 1'b0, 1'b0));
    send64(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, mk(64'h8000_0000_0000_0000, 1'b0, 1'b1));
    send64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, mk(64'h0000_0000_0000_0000, 1'b1, 1'b0));
    send64(64'h0000_0000_0001_0000, 64'd1, 1'b1, mk(64'h0000_0000_0000_FFFF, 1'b1, 1'b0));
    idle64(8);
    track = 1'b1;
    rec_first = 1'b1;
    for (int i = 0; i < 16; i++) begin
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      s = 1'($urandom);
      send64(x, y, s, model(64, x, y, s, 1'b0));
    end
    idle64(10);
    track = 1'b0;
    chk("lat_count", 64'(outc.size()), 64'd16);
    if (outc.size() == 16) begin
      chk("lat_first", 64'(outc[0]), 64'(acc0 + 3));
      for (int i = 1; i < 16; i++) chk("throughput", 64'(outc[i]), 64'(outc[i-1] + 1));
    end
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          if (gaps[i]) idle64(1);
          x = {$urandom, $urandom};
          y = {$urandom, $urandom};
          s = 1'($urandom);
          send64(x, y, s, model(64, x, y, s, 1'b0));
        end
        v64 = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1 r64 = 1'b0;
        repeat (3) @(posedge clk);
        #1 r64 = 1'b1;
      end
    join
    idle64(15);
    chk("bp_drained", 64'(q64.size()), 64'd0);
    for (int i = 0; i < 3; i++) begin
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      send64(x, y, 1'b0, model(64, x, y, 1'b0, 1'b0));
    end
    v64 = 1'b0;
    r64 = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ov", 64'(ov64), 64'd0);
    chk("midrst_sum", sum64, 64'd0);
    chk("midrst_carry", 64'(c64), 64'd0);
    chk("midrst_ovf", 64'(o64), 64'd0);
    chk("midrst_ir", 64'(ir64), 64'd1);
    q64.delete();
    r64 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      seen += int'(ov64);
    end
    chk("no_stale", 64'(seen), 64'd0);
    @(posedge clk); #1;
    send64(64'd5, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0));
    idle64(8);
    chk("q64_empty", 64'(q64.size()), 64'd0);
    chk("q8w_empty", 64'(q8w.size()), 64'd0);
    chk("q8s_empty", 64'(q8s.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
